// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          FIFO_DEPTH       = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } fetch_state_t;

  function automatic logic pc_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Two-entry {pc, instr} buffer with registered head; push lands on the head one cycle later.
// A full buffer accepts a push only alongside a pop; flush empties it in one cycle.
module ifetch_fifo
  import ifetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] din,
  output logic [ENTRY_W-1:0] head,
  output logic               full,
  output logic               empty
);

  localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

  logic [1:0]   count;
  fetch_entry_t slot0;
  fetch_entry_t slot1;
  logic         do_pop;
  logic         do_push;

  assign empty   = count == 2'd0;
  assign full    = count == DEPTH;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = slot0;

  // slot0 is always the head, so a pop shifts slot1 forward.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (empty) slot0 <= din;
          else       slot1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot0 <= din;
          end else begin
            slot0 <= slot1;
            slot1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: walks pc through a combinational imem into a 2-deep buffer toward decode.
// One cycle push-to-valid; stalls on full buffer unless popped; redirect flushes, misaligned target halts.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int          IMEM_ADDR_WIDTH = 10,
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]                imem_dout,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  output logic                       misalign_err
);

  logic [31:0]  pc;
  fetch_state_t state;
  fetch_state_t state_next;
  logic         fetch_en;
  logic         pop;
  logic         push;
  logic         fifo_full;
  logic         fifo_empty;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;

  // A redirect in the same cycle swallows both the pop and the push.
  assign pop  = out_valid && out_ready && !redirect_valid;
  assign push = fetch_en && !redirect_valid && (!fifo_full || pop);

  assign push_entry.pc    = pc;
  assign push_entry.instr = imem_dout;

  ifetch_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (push_entry),
    .head  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
    end else if (push) begin
      pc <= pc + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Only a redirect can leave or enter the halted state.
  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      state_next = pc_aligned(redirect_pc) ? ST_FETCH : ST_HALT;
    end
  end

  always_comb begin
    fetch_en     = 1'b0;
    misalign_err = 1'b0;
    unique case (state)
      ST_FETCH: fetch_en     = 1'b1;
      ST_HALT:  misalign_err = 1'b1;
      default:  ;
    endcase
  end

  assign imem_addr = pc[IMEM_ADDR_WIDTH+1:2];
  assign out_valid = !fifo_empty;
  assign out_pc    = head_entry.pc;
  assign out_instr = head_entry.instr;

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter IMEM_ADDR_WIDTH, default 10, word-address width of the instruction memory (1024 words = 4 KB).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address fetched first after reset.
REQ-003 SHALL have port clk  input  1  single clock, rising-edge active; one clock only.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port imem_addr  output  IMEM_ADDR_WIDTH  word address to the instruction memory, equal to pc[IMEM_ADDR_WIDTH+1:2].
REQ-006 SHALL have port imem_dout  input  32  instruction word returned combinationally, same cycle as imem_addr.
REQ-007 SHALL have port redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc.
REQ-008 SHALL have port redirect_pc  input  32  new fetch byte address.
REQ-009 SHALL have port out_valid  output  1  head entry valid toward decode.
REQ-010 SHALL have port out_ready  input  1  decode accepts the head entry.
REQ-011 SHALL have port out_pc  output  32  byte address of the head entry.
REQ-012 SHALL have port out_instr  output  32  instruction word of the head entry.
REQ-013 SHALL have port misalign_err  output  1  sticky flag; redirect target had pc[1:0] != 0.

Function
REQ-014 SHALL hold a 32-bit fetch pc register and a 2-entry FIFO of {pc, instr} pairs.
REQ-015 SHALL push {pc, imem_dout} and advance pc by 4 in any cycle where (FIFO not full OR pop occurs), no redirect is taken, and fetch is not halted.
REQ-016 SHALL define pop as out_valid && out_ready; out_pc/out_instr SHALL be the FIFO head, registered, with out_valid = FIFO not empty.
REQ-017 SHALL have a push-to-out_valid latency of exactly 1 cycle.
REQ-018 SHALL hold out_pc/out_instr stable while out_valid && !out_ready.
REQ-019 SHALL, on full FIFO with simultaneous pop, push in the same cycle (FIFO stays full, no bubble).
REQ-020 SHALL, on redirect_valid, flush all FIFO entries, discard any pop or push in that cycle, and load pc <= redirect_pc; out_valid SHALL be 0 the following cycle.
REQ-021 SHALL treat redirect as higher priority than pop and push when they occur in the same cycle.
REQ-022 SHALL, on a redirect with redirect_pc[1:0] != 0, set misalign_err, halt fetch (no push), and keep both until the next redirect with an aligned target, which clears misalign_err and resumes fetch.
REQ-023 SHALL let pc wrap modulo 2^32; imem_addr SHALL wrap by truncation past IMEM_DEPTH-1 words.
REQ-024 SHALL drive imem_addr from pc every cycle, including while the FIFO is full or fetch is halted.

Reset
REQ-025 SHALL, while reset is high, force pc = RESET_PC, FIFO empty, out_valid = 0, out_pc = 0, out_instr = 0, misalign_err = 0, asynchronously.
REQ-026 SHALL push its first entry (pc = RESET_PC) on the first rising clk edge after reset deasserts; a reset mid-stream SHALL discard all entries.

Structure
REQ-027 SHALL place RESET_PC default, FIFO depth constant (2), and typedef fetch_entry_t {pc[31:0], instr[31:0]} in shared package ifetch_pkg.
REQ-028 SHALL implement the buffer as sub-module ifetch_fifo (depth 2, push/pop/flush, full/empty), instantiated once.

Verification
REQ-029 SHALL test reset release with imem word i = 32'h1000_0000+i and out_ready=1 -> out_valid rises 2nd edge, out_pc = 0,4,8,... with out_instr = 32'h1000_0000,1,2 back-to-back.
REQ-030 SHALL test out_ready=0 for 5 cycles -> FIFO holds pcs 0 and 4, imem_addr stalls at 2; releasing ready gives pcs 0,4,8 with no gap or duplicate.
REQ-031 SHALL test redirect to 32'h0000_0100 with FIFO full and out_ready=1 same cycle -> no pop counted, out_valid=0 next cycle, then out_pc = 0x100, 0x104.
REQ-032 SHALL test redirect to 32'h0000_0102 -> misalign_err=1, no out_valid; later redirect to 0x200 -> misalign_err=0, out_pc = 0x200.
REQ-033 SHALL test redirect to 32'h0000_0FFC (IMEM_ADDR_WIDTH=10) -> imem_addr 1023 then 0, out_pc = 0xFFC then 0x1000.
REQ-034 SHALL test assertion of reset mid-stream with entries buffered -> out_valid=0 immediately (asynchronous), restart at RESET_PC after release.
